// File: rtl/rob_mport.sv
// Multi-port reorder buffer: tags upstream requests with a slot number, accepts
// out-of-order completions on several memory ports and retires them in request order.
module rob_mport #(
   parameter int ROB_SIZE = 16,
   parameter int SWIDTH   = 4,
   parameter int AWIDTH   = 40,
   parameter int DWIDTH   = 32,
   parameter int PWIDTH   = 32,
   parameter int IDWIDTH  = 16,
   parameter int MPORTS   = 2
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       req_val,
   input  logic [AWIDTH-1:0]          req_addr,
   input  logic [IDWIDTH-1:0]         req_ID,
   input  logic [PWIDTH-1:0]          req_param,
   output logic                       req_ready,
   output logic                       rsp_val,
   output logic [DWIDTH-1:0]          rsp_data,
   output logic [IDWIDTH-1:0]         rsp_ID,
   output logic [PWIDTH-1:0]          rsp_param,
   input  logic                       rsp_ready,
   output logic                       mem_req_val,
   output logic [AWIDTH-1:0]          mem_req_addr,
   output logic [SWIDTH-1:0]          mem_req_ID,
   input  logic                       mem_req_ready,
   input  logic [MPORTS-1:0]          mem_rsp_val,
   input  logic [MPORTS*SWIDTH-1:0]   mem_rsp_ID,
   input  logic [MPORTS*DWIDTH-1:0]   mem_rsp_data,
   output logic [SWIDTH:0]            occupancy,
   output logic                       err
);

   localparam logic [SWIDTH:0] FULL_CNT = (SWIDTH+1)'(ROB_SIZE);

   // Handshakes: a transfer happens in a cycle where valid and ready are both high
   // at the rising edge; valid never waits on ready, and payload is held while stalled.

   logic [SWIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [SWIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [SWIDTH:0]    cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [ROB_SIZE-1:0] alloc_q, alloc_d;
   logic [ROB_SIZE-1:0] done_q, done_d;
   logic [IDWIDTH-1:0] id_q    [ROB_SIZE];
   logic [PWIDTH-1:0]  param_q [ROB_SIZE];
   logic [DWIDTH-1:0]  data_q  [ROB_SIZE];

   logic               full;
   logic               do_acc;
   logic               do_ret;
   logic [MPORTS-1:0]  comp_ok;
   logic               comp_err;
   logic               dup;
   logic [SWIDTH-1:0]  comp_slot [MPORTS];

   assign full         = (cnt_q == FULL_CNT);
   assign req_ready    = ~full & mem_req_ready & rst_;
   assign mem_req_val  = req_val & ~full & rst_;
   assign mem_req_addr = req_addr;
   assign mem_req_ID   = wr_ptr_q;
   assign do_acc       = req_val & req_ready;

   assign rsp_val   = alloc_q[rd_ptr_q] & done_q[rd_ptr_q] & rst_;
   assign rsp_data  = data_q[rd_ptr_q];
   assign rsp_ID    = id_q[rd_ptr_q];
   assign rsp_param = param_q[rd_ptr_q];
   assign do_ret    = rsp_val & rsp_ready;

   assign occupancy = cnt_q;
   assign err       = err_q;

   // Completion filter: a lower-index port claiming the same slot always wins.
   always_comb begin
      comp_ok  = '0;
      comp_err = 1'b0;
      dup      = 1'b0;
      for (int p = 0; p < MPORTS; p++) begin
         comp_slot[p] = mem_rsp_ID[p*SWIDTH +: SWIDTH];
      end
      for (int p = 0; p < MPORTS; p++) begin
         dup = 1'b0;
         for (int q = 0; q < MPORTS; q++) begin
            if ((q < p) && mem_rsp_val[q] && (comp_slot[q] == comp_slot[p])) begin
               dup = 1'b1;
            end
         end
         if (mem_rsp_val[p]) begin
            if (!dup && alloc_q[comp_slot[p]] && !done_q[comp_slot[p]]) begin
               comp_ok[p] = 1'b1;
            end else begin
               comp_err = 1'b1;
            end
         end
      end
   end

   always_comb begin
      alloc_d  = alloc_q;
      done_d   = done_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q | comp_err;
      for (int p = 0; p < MPORTS; p++) begin
         if (comp_ok[p]) begin
            done_d[comp_slot[p]] = 1'b1;
         end
      end
      // Accept and retire never touch the same slot: that needs full or empty.
      if (do_acc) begin
         alloc_d[wr_ptr_q] = 1'b1;
         done_d[wr_ptr_q]  = 1'b0;
         wr_ptr_d          = wr_ptr_q + SWIDTH'(1);
      end
      if (do_ret) begin
         alloc_d[rd_ptr_q] = 1'b0;
         done_d[rd_ptr_q]  = 1'b0;
         rd_ptr_d          = rd_ptr_q + SWIDTH'(1);
      end
      case ({do_acc, do_ret})
         2'b10:   cnt_d = cnt_q + (SWIDTH+1)'(1);
         2'b01:   cnt_d = cnt_q - (SWIDTH+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         alloc_q  <= '0;
         done_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         alloc_q  <= alloc_d;
         done_q   <= done_d;
      end
   end

   // Payload storage is qualified by alloc/done, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_acc) begin
         id_q[wr_ptr_q]    <= req_ID;
         param_q[wr_ptr_q] <= req_param;
      end
      for (int p = 0; p < MPORTS; p++) begin
         if (comp_ok[p]) begin
            data_q[comp_slot[p]] <= mem_rsp_data[p*DWIDTH +: DWIDTH];
         end
      end
   end

endmodule

// File: doc/rob_mport.md
# rob_mport

Multi-port reorder buffer, successor to the single-port ROB. Accepts tagged upstream requests and forwards them to memory with a slot tag. Accepts out-of-order completions on MPORTS parallel memory response ports. Retires responses strictly in request order on a val/ready port. Adds memory-side backpressure, an occupancy output and sticky protocol-error detection.

## Interface
- ROB_SIZE, 16: number of slots; must equal 2**SWIDTH
- SWIDTH, 4: slot tag width
- AWIDTH, 40: address width
- DWIDTH, 32: response data width
- PWIDTH, 32: request side-parameter width, carried through to the response
- IDWIDTH, 16: upstream ID width, carried through to the response
- MPORTS, 2: number of memory response ports (≥1)
- clk  in  1  clock; all logic on rising edge
- rst_  in  1  synchronous reset, active low
- req_val  in  1  upstream request valid
- req_addr  in  AWIDTH  request address
- req_ID  in  IDWIDTH  request ID
- req_param  in  PWIDTH  request parameter
- req_ready  out  1  request accepted when req_val & req_ready
- rsp_val  out  1  in-order response valid
- rsp_data  out  DWIDTH  response data
- rsp_ID  out  IDWIDTH  ID of retired request
- rsp_param  out  PWIDTH  param of retired request
- rsp_ready  in  1  downstream ready
- mem_req_val  out  1  memory request valid
- mem_req_addr  out  AWIDTH  equals req_addr
- mem_req_ID  out  SWIDTH  slot tag
- mem_req_ready  in  1  memory accepts request
- mem_rsp_val  in  MPORTS  per-port completion valid; never backpressured
- mem_rsp_ID  in  MPORTS*SWIDTH  per-port slot tag; port p at [p*SWIDTH +: SWIDTH]
- mem_rsp_data  in  MPORTS*DWIDTH  per-port data; port p at [p*DWIDTH +: DWIDTH]
- occupancy  out  SWIDTH+1  allocated slot count
- err  out  1  sticky protocol error

## Operation
- State:
  - Write pointer wr_ptr and read pointer rd_ptr, each SWIDTH bits; they wrap naturally modulo ROB_SIZE.
  - Counter cnt, SWIDTH+1 bits.
  - Per slot: alloc, done, ID, param and data registers.
- Allocation:
  - full = (cnt == ROB_SIZE), computed from registered cnt.
  - mem_req_val = req_val & ~full & rst_.
  - req_ready = ~full & mem_req_ready & rst_.
  - mem_req_ID = wr_ptr.
  - On req_val & req_ready, the slot at wr_ptr is written: alloc=1, done=0, ID and param stored. wr_ptr then increments.
  - mem_req_val does not depend on mem_req_ready.
- Completion:
  - For each port p with mem_rsp_val[p], slot s = mem_rsp_ID[p].
  - If alloc[s] & ~done[s]: data[s] is written and done[s] is set.
  - Otherwise the completion is dropped and err is set.
  - Two or more ports carrying the same s in one cycle: the lowest-index port wins, the others are dropped, and err is set.
  - Completions to distinct slots in one cycle are all accepted.
- Retire:
  - rsp_val = alloc[rd_ptr] & done[rd_ptr]. rsp_data, rsp_ID and rsp_param are read from slot rd_ptr.
  - On rsp_val & rsp_ready: alloc and done at rd_ptr clear, and rd_ptr increments.
- Counter:
  - cnt gains +1 on accept and −1 on retire; both in one cycle leave it unchanged.
  - occupancy = cnt.
- A slot freed by retire in cycle N is allocatable no earlier than cycle N+1. When full, req_ready stays low in the retire cycle.
- err is cleared only by reset.

## Timing
- Reset (rst_ low at a clock edge) clears wr_ptr, rd_ptr, cnt, err, and all alloc and done bits.
- While rst_ is low, req_ready, mem_req_val and rsp_val are 0 combinationally.
- After rst_ rises: occupancy=0, err=0, req_ready=mem_req_ready.
- Reset mid-operation discards all outstanding slots. Memory completions arriving after reset see alloc=0 and set err.
- Request to memory: combinational passthrough, zero cycles.
- Completion to rsp_val: the earliest is 1 cycle. mem_rsp in cycle N gives rsp_val in N+1 when the slot is the head.
- Head retire to next head: consecutive done slots retire one per cycle with rsp_ready held high.
- There is no combinational path from mem_rsp_* or rsp_ready to any output. rsp_* outputs are functions of registers only.
- rsp_* are held stable while rsp_val & ~rsp_ready.
- A completion for the head arriving in the same cycle as its retire cannot occur (done is already 1). A completion to a non-head slot in a retire cycle is accepted normally.

## Test plan
- Single request: req_ID=0x0005, req_param=0x11, addr=0x40; memory returns tag 0 with data 0xAB on port 1 two cycles later. Expect one rsp: ID=0x0005, param=0x11, data=0xAB, asserted exactly 1 cycle after the completion; occupancy returns 0.
- Fill 16 requests with memory idle. Expect occupancy=16, req_ready=0. Complete tag 0 and retire it. Expect req_ready low during the retire cycle and high the next cycle.
- Reverse-order completion: tags 15..0 on alternating ports, two per cycle. Expect rsp_ID to come out strictly 0..15, with data equal to the tag.
- Same tag 3 on ports 0 and 1 in one cycle, with data 0x30 and 0x31. Expect data 0x30 retired and err=1. A completion to an unallocated tag 9 also sets err.
- mem_req_ready low for 5 cycles with req_val high. Expect no accept and req_addr held; acceptance resumes the cycle mem_req_ready rises.
- Random stall on rsp_ready for 1000 requests with wrap-around. Expect the ID sequence incrementing, no loss, and err=0. Assert rst_ mid-stream: expect occupancy=0 and rsp_val=0 the next cycle.
